mpp_prog_mem: RTL and testbench
===============================

MPP_PROG_MEM -- requirements
Module: mpp_prog_mem

Interface
REQ-001 Parameter ADDR_W, default 8, array address width (depth 2**ADDR_W bytes).
REQ-002 Parameter FILL_BYTE, default 8'h00, byte returned for out-of-range fetches.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 program_addr  input  16  fetch address from processor.
REQ-006 out_signals  input  5  processor control bus; bit 1 is the fetch strobe (active high), other bits ignored.
REQ-007 instruction  output  8  fetched byte, registered.
REQ-008 instr_valid  output  1  one-cycle pulse marking new instruction data.
REQ-009 load_we  input  1  loader write enable.
REQ-010 load_addr  input  ADDR_W  loader write address.
REQ-011 load_data  input  8  loader write data.
REQ-012 oob_err  output  1  sticky out-of-range fetch flag.
REQ-013 fetch_count  output  16  count of completed fetches.

Function
REQ-014 Strobe shall be registered; a fetch shall start on a sampled 0->1 transition only.
REQ-015 FSM states: IDLE, READ, HOLD; IDLE->READ on strobe rise, capturing program_addr; READ->HOLD unconditionally; HOLD->IDLE when sampled strobe is 0.
REQ-016 In READ, instruction shall load array[addr] and instr_valid shall pulse, i.e. data valid at the second edge after the edge sampling the strobe rise.
REQ-017 instruction shall hold its value until the next completed fetch.
REQ-018 Strobe falling during READ shall not abort the fetch; READ completes, then HOLD exits next cycle.
REQ-019 Captured address with any bit [15:ADDR_W] set shall return FILL_BYTE and set oob_err; array is not read.
REQ-020 load_we shall write load_data to array[load_addr] in any state, one write per cycle.
REQ-021 Write in the same cycle as a READ of the same address shall bypass: instruction returns load_data.
REQ-022 fetch_count shall increment by 1 per instr_valid pulse, saturating at 16'hFFFF.

Reset
REQ-023 rst_n low shall immediately force state IDLE, instruction 8'h00, instr_valid 0, oob_err 0, fetch_count 0, strobe register 0.
REQ-024 Array contents shall be unaffected by reset.
REQ-025 Reset during READ shall discard the fetch; no instr_valid pulse follows.

Configuration
REQ-026 With MPP_PROG_MEM_PREFETCH_EN defined: on each completed fetch of address A, byte at A+1 (wrapping 2**ADDR_W-1 -> 0) shall be read into a one-entry prefetch buffer with its address and valid bit.
REQ-027 With MPP_PROG_MEM_PREFETCH_EN, a strobe rise whose in-range address matches the valid buffer shall go IDLE->HOLD, returning buffer data with instr_valid at the first edge after the edge sampling the strobe rise; a miss uses the normal READ path.
REQ-028 With MPP_PROG_MEM_PREFETCH_EN, a load write to the buffered address shall invalidate the buffer; reset shall clear valid.
REQ-029 Without MPP_PROG_MEM_PREFETCH_EN, no buffer logic exists and all fetches follow REQ-015/016.

Structure
REQ-030 Package mpp_pkg shall hold the FSM state enum, strobe bit index (1), and default FILL_BYTE.
REQ-031 Prefetch buffer shall be sub-module mpp_prefetch_buf, instantiated only under MPP_PROG_MEM_PREFETCH_EN.

Verification
REQ-032 Load 0x00..0x04 with 07,C0,44,C1,CB; fetch addresses 0..4 -> instruction 07,C0,44,C1,CB, each with one instr_valid pulse, fetch_count=5.
REQ-033 Fetch 16'h0100 with ADDR_W=8 -> instruction 8'h00, oob_err=1, stays 1 after later in-range fetches.
REQ-034 Same-cycle load_we to 0x05 (data 8'hAA) during READ of 0x05 -> instruction 8'hAA.
REQ-035 Assert rst_n low one cycle into READ -> no instr_valid, instruction 8'h00, array byte at 0x00 still 07.
REQ-036 Prefetch build: fetch 0x0F then 0x10 -> 0x10 returned one cycle earlier than miss; fetch 0xFF then 0x00 -> wrap hit; load 0x10 after fetching 0x0F -> miss latency.

Source files
------------

// File: rtl/mpp_pkg.sv
`default_nettype none
// ============================================================================
// mpp_pkg : shared types and constants for the mpp_prog_mem program memory.
// Rev 1.0
// ============================================================================
package mpp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int         STROBE_BIT        = 1;
  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'h00;

  // True when no address bit at or above the array width is set.
  function automatic logic addr_in_range(input logic [15:0] addr, input int aw);
    return (addr >> aw) == 16'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpp_prefetch_buf.sv
`default_nettype none
// ============================================================================
// mpp_prefetch_buf : one-entry next-byte buffer; a fill wins over an
// invalidating write to the same entry in the same cycle.  Rev 1.0
// ============================================================================
module mpp_prefetch_buf
  import mpp_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [7:0]        fill_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              buf_valid,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= 8'h00;
    end else if (fill_en) begin
      buf_valid <= 1'b1;
      buf_addr  <= fill_addr;
      buf_data  <= fill_data;
    end else if (wr_en && buf_valid && (wr_addr == buf_addr)) begin
      buf_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mpp_prog_mem.sv
`default_nettype none
// ============================================================================
// mpp_prog_mem : loadable byte program memory with strobed fetch FSM.
// Define MPP_PROG_MEM_PREFETCH_EN to add a next-byte prefetch buffer. Rev 1.0
// ============================================================================
module mpp_prog_mem
  import mpp_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       program_addr,
  input  logic [4:0]        out_signals,
  output logic [7:0]        instruction,
  output logic              instr_valid,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              oob_err,
  output logic [15:0]       fetch_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0]        r_mem [DEPTH];
  logic              r_strobe;
  logic              r_strobe_d;
  state_t            r_state;
  logic [15:0]       r_addr;

  logic              w_rise;
  logic              w_addr_ok;
  logic [ADDR_W-1:0] w_rd_idx;
  logic [7:0]        w_rd_data;
  logic [15:0]       w_count_next;
  logic              w_hit;
  logic [7:0]        w_hit_data;

  // Array has no reset so loaded code survives a processor reset.
  always_ff @(posedge clk) begin
    if (load_we) begin
      r_mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strobe   <= 1'b0;
      r_strobe_d <= 1'b0;
    end else begin
      r_strobe   <= out_signals[STROBE_BIT];
      r_strobe_d <= r_strobe;
    end
  end

  assign w_rise       = r_strobe & ~r_strobe_d;
  assign w_rd_idx     = r_addr[ADDR_W-1:0];
  assign w_addr_ok    = addr_in_range(r_addr, ADDR_W);
  assign w_rd_data    = (load_we && (load_addr == w_rd_idx)) ? load_data : r_mem[w_rd_idx];
  assign w_count_next = (fetch_count == 16'hFFFF) ? fetch_count : fetch_count + 16'd1;

`ifdef MPP_PROG_MEM_PREFETCH_EN
  logic              w_pa_ok;
  logic [ADDR_W-1:0] w_pa_idx;
  logic [ADDR_W-1:0] w_fill_base;
  logic [ADDR_W-1:0] w_fill_addr;
  logic              w_fill_en;
  logic [7:0]        w_fill_data;
  logic              w_buf_valid;
  logic [ADDR_W-1:0] w_buf_addr;
  logic [7:0]        w_buf_data;

  assign w_pa_idx    = program_addr[ADDR_W-1:0];
  assign w_pa_ok     = addr_in_range(program_addr, ADDR_W);
  assign w_hit       = w_buf_valid && w_pa_ok && (w_pa_idx == w_buf_addr);
  assign w_hit_data  = (load_we && (load_addr == w_pa_idx)) ? load_data : w_buf_data;

  // Every completed in-range fetch, hit or miss, queues up the following byte.
  assign w_fill_en   = ((r_state == ST_READ) && w_addr_ok) ||
                       ((r_state == ST_IDLE) && w_rise && w_hit);
  assign w_fill_base = (r_state == ST_READ) ? w_rd_idx : w_pa_idx;
  assign w_fill_addr = w_fill_base + ADDR_W'(1);
  assign w_fill_data = (load_we && (load_addr == w_fill_addr)) ? load_data : r_mem[w_fill_addr];

  mpp_prefetch_buf #(
    .ADDR_W(ADDR_W)
  ) u_prefetch_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .fill_en  (w_fill_en),
    .fill_addr(w_fill_addr),
    .fill_data(w_fill_data),
    .wr_en    (load_we),
    .wr_addr  (load_addr),
    .buf_valid(w_buf_valid),
    .buf_addr (w_buf_addr),
    .buf_data (w_buf_data)
  );
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= 16'h0000;
      instruction <= 8'h00;
      instr_valid <= 1'b0;
      oob_err     <= 1'b0;
      fetch_count <= 16'h0000;
    end else begin
      instr_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_addr <= program_addr;
            if (w_hit) begin
              instruction <= w_hit_data;
              instr_valid <= 1'b1;
              fetch_count <= w_count_next;
              r_state     <= ST_HOLD;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (w_addr_ok) begin
            instruction <= w_rd_data;
          end else begin
            instruction <= FILL_BYTE;
            oob_err     <= 1'b1;
          end
          instr_valid <= 1'b1;
          fetch_count <= w_count_next;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!r_strobe) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mpp_prog_mem.sv
`default_nettype none
// ============================================================================
// tb_mpp_prog_mem : randomized fetch/load traffic against a transaction-level
// model of the program memory, plus literal checks of the key scenarios.
// ============================================================================
module tb_mpp_prog_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] program_addr;
  logic [4:0]  out_signals;
  logic [7:0]  instruction;
  logic        instr_valid;
  logic        load_we;
  logic [7:0]  load_addr;
  logic [7:0]  load_data;
  logic        oob_err;
  logic [15:0] fetch_count;

  always #5 clk = ~clk;

  mpp_prog_mem #(
    .ADDR_W   (8),
    .FILL_BYTE(8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .program_addr(program_addr),
    .out_signals (out_signals),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .oob_err     (oob_err),
    .fetch_count (fetch_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          edge_c;
    logic [15:0] addr;
  } req_t;

  req_t        reqq[$];
  int          cyc = 0;
  int          last_valid_cyc = 0;
  logic [7:0]  mem [256];
  logic        sched_v = 1'b0;
  int          sched_edge = 0;
  logic [15:0] sched_addr = 16'h0;
  logic [7:0]  exp_instr = 8'h00;
  logic        exp_valid = 1'b0;
  logic        exp_oob = 1'b0;
  int          exp_cnt = 0;
  logic        fill_p;
  logic [7:0]  fill_a;
  logic [7:0]  fill_d;
`ifdef MPP_PROG_MEM_PREFETCH_EN
  logic        buf_v = 1'b0;
  logic [7:0]  buf_a = 8'h00;
  logic [7:0]  buf_d = 8'h00;
`endif

  function automatic logic [7:0] byp(input logic [7:0] a, input logic [7:0] d);
    return (load_we && load_addr == a) ? load_data : d;
  endfunction

  task automatic complete(input logic [7:0] a, input logic [7:0] d, input logic oob);
    exp_instr      = d;
    exp_valid      = 1'b1;
    last_valid_cyc = cyc;
    if (oob) exp_oob = 1'b1;
    if (exp_cnt < 65535) exp_cnt++;
    if (!oob) begin
      fill_p = 1'b1;
      fill_a = a + 8'd1;
      fill_d = byp(fill_a, mem[fill_a]);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqq.delete();
      sched_v   = 1'b0;
      exp_instr = 8'h00;
      exp_valid = 1'b0;
      exp_oob   = 1'b0;
      exp_cnt   = 0;
`ifdef MPP_PROG_MEM_PREFETCH_EN
      buf_v = 1'b0;
`endif
    end else begin
      req_t r;
      cyc++;
      exp_valid = 1'b0;
      fill_p    = 1'b0;
      if (sched_v && sched_edge == cyc) begin
        sched_v = 1'b0;
        if (sched_addr[15:8] != 8'h00) complete(sched_addr[7:0], 8'h00, 1'b1);
        else complete(sched_addr[7:0], byp(sched_addr[7:0], mem[sched_addr[7:0]]), 1'b0);
      end
      if (reqq.size() > 0 && reqq[0].edge_c == cyc) begin
        r = reqq.pop_front();
`ifdef MPP_PROG_MEM_PREFETCH_EN
        if (r.addr[15:8] == 8'h00 && buf_v && buf_a == r.addr[7:0]) begin
          complete(r.addr[7:0], byp(r.addr[7:0], buf_d), 1'b0);
        end else
`endif
        begin
          sched_v    = 1'b1;
          sched_edge = cyc + 1;
          sched_addr = r.addr;
        end
      end
      if (load_we) mem[load_addr] = load_data;
`ifdef MPP_PROG_MEM_PREFETCH_EN
      if (load_we && buf_v && load_addr == buf_a) buf_v = 1'b0;
      if (fill_p) begin
        buf_v = 1'b1;
        buf_a = fill_a;
        buf_d = fill_d;
      end
`endif
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    #1;
    chk("instr_valid", 16'(instr_valid), 16'(exp_valid));
    chk("instruction", 16'(instruction), 16'(exp_instr));
    chk("oob_err", 16'(oob_err), 16'(exp_oob));
    chk("fetch_count", fetch_count, 16'(exp_cnt));
  end

  // ---------------- stimulus ----------------
  logic rand_wr = 1'b0;

  task automatic drive(input logic stb, input logic wr, input logic [7:0] wa, input logic [7:0] wd);
    @(negedge clk);
    out_signals    = 5'($urandom);
    out_signals[1] = stb;
    if (wr) begin
      load_we = 1'b1; load_addr = wa; load_data = wd;
    end else if (rand_wr && $urandom_range(0, 3) == 0) begin
      load_we = 1'b1; load_addr = 8'($urandom); load_data = 8'($urandom);
    end else begin
      load_we = 1'b0;
    end
  endtask

  // Strobe high for h cycles then low for g cycles (h+g >= 3 keeps the FSM idle
  // before the next rise); optional forced write at cycle index wr_i.
  task automatic fetch(input logic [15:0] a, input int h, input int g, input int wr_i,
                       input logic [7:0] wa, input logic [7:0] wd, output int e0);
    e0 = 0;
    for (int i = 0; i < h + g; i++) begin
      drive(i < h, i == wr_i, wa, wd);
      if (i == 0) begin
        program_addr = a;
        e0 = cyc + 1;
        reqq.push_back('{edge_c: cyc + 2, addr: a});
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [7:0] tbl [5];
  int         e0;
  int         exp_lat;
  logic [15:0] ra;
  logic [15:0] prev_a;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = 8'h07; tbl[1] = 8'hC0; tbl[2] = 8'h44; tbl[3] = 8'hC1; tbl[4] = 8'hCB;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; program_addr = 16'h0; out_signals = 5'h0;
    load_we = 1'b0; load_addr = 8'h0; load_data = 8'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) drive(1'b0, 1'b1, 8'(i), 8'($urandom));
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'(i), tbl[i]);
    drive(1'b0, 1'b0, 8'h0, 8'h0);

    // Basic fetches of the loaded program
    for (int i = 0; i < 5; i++) begin
      fetch(16'(i), 2, 2, -1, 8'h0, 8'h0, e0);
`ifdef MPP_PROG_MEM_PREFETCH_EN
      exp_lat = (i == 0) ? 2 : 1;
`else
      exp_lat = 2;
`endif
      chk("basic_instr", 16'(instruction), 16'(tbl[i]));
      chk("basic_latency", 16'(last_valid_cyc - e0), 16'(exp_lat));
    end
    chk("basic_count", fetch_count, 16'd5);

    // Out-of-range fetch and sticky error
    fetch(16'h0100, 1, 3, -1, 8'h0, 8'h0, e0);
    chk("oob_instr", 16'(instruction), 16'h0000);
    chk("oob_flag", 16'(oob_err), 16'h0001);
    fetch(16'h0002, 3, 2, -1, 8'h0, 8'h0, e0);
    chk("oob_sticky_instr", 16'(instruction), 16'h0044);
    chk("oob_sticky_flag", 16'(oob_err), 16'h0001);

    // Write bypass at the READ edge
    fetch(16'h0005, 2, 2, 2, 8'h05, 8'hAA, e0);
    chk("bypass_instr", 16'(instruction), 16'h00AA);

    // Reset one cycle into READ
    drive(1'b1, 1'b0, 8'h0, 8'h0);
    program_addr = 16'h0000;
    reqq.push_back('{edge_c: cyc + 2, addr: 16'h0000});
    drive(1'b1, 1'b0, 8'h0, 8'h0);
    @(negedge clk);
    rst_n = 1'b0; out_signals = 5'h0; load_we = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid", 16'(instr_valid), 16'h0000);
    chk("rst_instr", 16'(instruction), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 8'h0, 8'h0);
    chk("rst_no_pulse_count", fetch_count, 16'h0000);
    fetch(16'h0000, 2, 2, -1, 8'h0, 8'h0, e0);
    chk("rst_array_kept", 16'(instruction), 16'h0007);

`ifdef MPP_PROG_MEM_PREFETCH_EN
    fetch(16'h000F, 2, 2, -1, 8'h0, 8'h0, e0);
    fetch(16'h0010, 2, 2, -1, 8'h0, 8'h0, e0);
    chk("pf_hit_latency", 16'(last_valid_cyc - e0), 16'd1);
    fetch(16'h00FF, 2, 2, -1, 8'h0, 8'h0, e0);
    fetch(16'h0000, 2, 2, -1, 8'h0, 8'h0, e0);
    chk("pf_wrap_latency", 16'(last_valid_cyc - e0), 16'd1);
    chk("pf_wrap_instr", 16'(instruction), 16'h0007);
    fetch(16'h000F, 2, 2, -1, 8'h0, 8'h0, e0);
    drive(1'b0, 1'b1, 8'h10, 8'h5A);
    fetch(16'h0010, 2, 2, -1, 8'h0, 8'h0, e0);
    chk("pf_inval_latency", 16'(last_valid_cyc - e0), 16'd2);
    chk("pf_inval_instr", 16'(instruction), 16'h005A);
`endif

    // Randomized traffic with concurrent loader writes
    rand_wr = 1'b1;
    prev_a  = 16'h0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) ra = {8'($urandom_range(1, 255)), 8'($urandom)};
      else if ($urandom_range(0, 2) == 0) ra = {8'h00, prev_a[7:0] + 8'd1};
      else ra = {8'h00, 8'($urandom)};
      prev_a = ra;
      fetch(ra, int'($urandom_range(1, 3)), int'($urandom_range(2, 4)), -1, 8'h0, 8'h0, e0);
    end
    rand_wr = 1'b0;
    repeat (5) drive(1'b0, 1'b0, 8'h0, 8'h0);
    chk("drain", 16'(reqq.size() + int'(sched_v)), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
